// File: rtl/rs_issue_sched_if.sv
// rs_issue_sched_if -- dispatch / wakeup / issue signal bundle for the
// reservation-station scheduler.
//
// Handshake: the issue side is strict valid/ready. issue_valid and
// issue_payload never depend on issue_ready. A transfer (fire) happens on a
// rising clk edge where issue_valid & issue_ready are both high. Dispatch is
// a write-enable (dispatch_we) qualified by is_full: a write while is_full is
// high is dropped, so the producer must stall on is_full.
//
// Modports:
//   master : upstream/FU side (drives dispatch, cdb, issue_ready)
//   slave  : the scheduler (drives is_full, issue_valid, issue_payload)
interface rs_issue_sched_if #(
  parameter int TAG_W     = 6,
  parameter int PAYLOAD_W = 64
);
  logic                 dispatch_we;
  logic [PAYLOAD_W-1:0] dispatch_payload;
  logic [TAG_W-1:0]     dispatch_src1_tag;
  logic                 dispatch_src1_rdy;
  logic [TAG_W-1:0]     dispatch_src2_tag;
  logic                 dispatch_src2_rdy;
  logic                 is_full;
  logic                 cdb_valid;
  logic [TAG_W-1:0]     cdb_tag;
  logic                 issue_valid;
  logic                 issue_ready;
  logic [PAYLOAD_W-1:0] issue_payload;

  modport master (
    output dispatch_we, dispatch_payload, dispatch_src1_tag, dispatch_src1_rdy,
           dispatch_src2_tag, dispatch_src2_rdy, cdb_valid, cdb_tag, issue_ready,
    input  is_full, issue_valid, issue_payload
  );

  modport slave (
    input  dispatch_we, dispatch_payload, dispatch_src1_tag, dispatch_src1_rdy,
           dispatch_src2_tag, dispatch_src2_rdy, cdb_valid, cdb_tag, issue_ready,
    output is_full, issue_valid, issue_payload
  );
endinterface

// File: rtl/rs_issue_sched.sv
// rs_issue_sched -- age-ordered reservation station for one functional unit.
//
// Entries are kept compacted with slot 0 the oldest. Sources wake from CDB
// tag broadcasts (including same-cycle bypass on dispatch); the oldest entry
// with both sources ready is offered on the issue port. On fire the selected
// entry is removed and younger entries shift down one slot.
//
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   flush      : squash all entries (mispredict / misload)
//   bus        : rs_issue_sched_if.slave (dispatch, cdb, issue, is_full)
//   occupancy, issue_stall_cnt : only when RS_OCCUPANCY_EN is defined;
//     registered entry count and a saturating count of cycles with
//     issue_valid & ~issue_ready (cleared by reset and flush).
//
// Optional feature macro: RS_OCCUPANCY_EN
module rs_issue_sched #(
  parameter int DEPTH     = 4,
  parameter int TAG_W     = 6,
  parameter int PAYLOAD_W = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic flush,
  rs_issue_sched_if.slave bus
`ifdef RS_OCCUPANCY_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0] occupancy,
  output logic [15:0]                issue_stall_cnt
`endif
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic                 valid_q   [DEPTH];
  logic [PAYLOAD_W-1:0] payload_q [DEPTH];
  logic [TAG_W-1:0]     s1_tag_q  [DEPTH];
  logic                 s1_rdy_q  [DEPTH];
  logic [TAG_W-1:0]     s2_tag_q  [DEPTH];
  logic                 s2_rdy_q  [DEPTH];
  logic [CW-1:0]        count_q;

  // Woken copy of current state, one extra zero slot so the shift-down can
  // read slot i+1 uniformly for the top entry.
  logic                 w_valid   [DEPTH+1];
  logic [PAYLOAD_W-1:0] w_payload [DEPTH+1];
  logic [TAG_W-1:0]     w_s1_tag  [DEPTH+1];
  logic                 w_s1_rdy  [DEPTH+1];
  logic [TAG_W-1:0]     w_s2_tag  [DEPTH+1];
  logic                 w_s2_rdy  [DEPTH+1];

  logic                 n_valid   [DEPTH];
  logic [PAYLOAD_W-1:0] n_payload [DEPTH];
  logic [TAG_W-1:0]     n_s1_tag  [DEPTH];
  logic                 n_s1_rdy  [DEPTH];
  logic [TAG_W-1:0]     n_s2_tag  [DEPTH];
  logic                 n_s2_rdy  [DEPTH];
  logic [CW-1:0]        n_count;

  logic          is_full, any_elig, issue_valid, fire, disp_ok;
  logic [IW-1:0] sel_idx;
  logic [CW-1:0] wr_idx;
  logic          d_s1_rdy, d_s2_rdy;

  assign is_full         = (count_q == CW'(DEPTH));
  assign issue_valid     = any_elig & ~flush;
  assign fire            = issue_valid & bus.issue_ready;
  assign disp_ok         = bus.dispatch_we & ~is_full & ~flush;
  // With a same-cycle issue the younger entries shift first, so the append
  // point moves down by one.
  assign wr_idx          = count_q - CW'(fire);
  assign d_s1_rdy        = bus.dispatch_src1_rdy | (bus.cdb_valid & (bus.cdb_tag == bus.dispatch_src1_tag));
  assign d_s2_rdy        = bus.dispatch_src2_rdy | (bus.cdb_valid & (bus.cdb_tag == bus.dispatch_src2_tag));
  assign bus.is_full     = is_full;
  assign bus.issue_valid = issue_valid;

  // Oldest-first select: scanning downward leaves the lowest eligible index.
  always_comb begin
    any_elig = 1'b0;
    sel_idx  = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (valid_q[i] && s1_rdy_q[i] && s2_rdy_q[i]) begin
        any_elig = 1'b1;
        sel_idx  = IW'(i);
      end
    end
    bus.issue_payload = issue_valid ? payload_q[sel_idx] : '0;
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_valid[i]   = valid_q[i];
      w_payload[i] = payload_q[i];
      w_s1_tag[i]  = s1_tag_q[i];
      w_s2_tag[i]  = s2_tag_q[i];
      w_s1_rdy[i]  = s1_rdy_q[i] | (bus.cdb_valid & (bus.cdb_tag == s1_tag_q[i]));
      w_s2_rdy[i]  = s2_rdy_q[i] | (bus.cdb_valid & (bus.cdb_tag == s2_tag_q[i]));
    end
    w_valid[DEPTH]   = 1'b0;
    w_payload[DEPTH] = '0;
    w_s1_tag[DEPTH]  = '0;
    w_s1_rdy[DEPTH]  = 1'b0;
    w_s2_tag[DEPTH]  = '0;
    w_s2_rdy[DEPTH]  = 1'b0;

    for (int i = 0; i < DEPTH; i++) begin
      if (fire && (IW'(i) >= sel_idx)) begin
        n_valid[i]   = w_valid[i+1];
        n_payload[i] = w_payload[i+1];
        n_s1_tag[i]  = w_s1_tag[i+1];
        n_s1_rdy[i]  = w_s1_rdy[i+1];
        n_s2_tag[i]  = w_s2_tag[i+1];
        n_s2_rdy[i]  = w_s2_rdy[i+1];
      end else begin
        n_valid[i]   = w_valid[i];
        n_payload[i] = w_payload[i];
        n_s1_tag[i]  = w_s1_tag[i];
        n_s1_rdy[i]  = w_s1_rdy[i];
        n_s2_tag[i]  = w_s2_tag[i];
        n_s2_rdy[i]  = w_s2_rdy[i];
      end
      if (disp_ok && (CW'(i) == wr_idx)) begin
        n_valid[i]   = 1'b1;
        n_payload[i] = bus.dispatch_payload;
        n_s1_tag[i]  = bus.dispatch_src1_tag;
        n_s1_rdy[i]  = d_s1_rdy;
        n_s2_tag[i]  = bus.dispatch_src2_tag;
        n_s2_rdy[i]  = d_s2_rdy;
      end
      if (flush) n_valid[i] = 1'b0;
    end
    n_count = flush ? '0 : (count_q + CW'(disp_ok) - CW'(fire));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '{default: 1'b0};
      count_q <= '0;
    end else begin
      valid_q <= n_valid;
      count_q <= n_count;
    end
  end

  // Entry contents are don't-care while the valid bit is low.
  always_ff @(posedge clk) begin
    payload_q <= n_payload;
    s1_tag_q  <= n_s1_tag;
    s1_rdy_q  <= n_s1_rdy;
    s2_tag_q  <= n_s2_tag;
    s2_rdy_q  <= n_s2_rdy;
  end

`ifdef RS_OCCUPANCY_EN
  assign occupancy = count_q;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      issue_stall_cnt <= '0;
    end else if (issue_valid && !bus.issue_ready && (issue_stall_cnt != 16'hFFFF)) begin
      issue_stall_cnt <= issue_stall_cnt + 16'd1;
    end
  end
`endif
endmodule

// File: doc/rs_issue_sched.md
Name: rs_issue_sched

Overview:
- Age-ordered reservation-station scheduler for one functional unit (integer, branch or load/store instance).
- Accepts dispatched micro-ops and wakes source operands from common-data-bus (CDB) tag broadcasts.
- Issues the oldest fully-ready entry to the unit through a valid/ready handshake.
- Provides the `is_full` flag the dispatch stall logic consumes; clears all state on a mispredict/misload flush.

Parameters:
- DEPTH, 4, number of entries (2..16).
- TAG_W, 6, physical-register/ROB tag width.
- PAYLOAD_W, 64, opaque micro-op payload width, passed through unchanged.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  mispredict/misload squash, driven by `signal_miss`.
- dispatch_we  in  1  write one micro-op this cycle.
- dispatch_payload  in  PAYLOAD_W  micro-op body.
- dispatch_src1_tag  in  TAG_W  producer tag of source 1.
- dispatch_src1_rdy  in  1  source 1 already available.
- dispatch_src2_tag  in  TAG_W  producer tag of source 2.
- dispatch_src2_rdy  in  1  source 2 already available.
- is_full  out  1  high when count == DEPTH.
- cdb_valid  in  1  broadcast valid.
- cdb_tag  in  TAG_W  broadcast producer tag.
- issue_valid  out  1  an entry is ready to issue.
- issue_ready  in  1  functional unit accepts.
- issue_payload  out  PAYLOAD_W  payload of the selected entry.

Behaviour:
- Storage: DEPTH slots, each holding valid, payload, src1_tag, src1_rdy, src2_tag, src2_rdy. Slots are kept compacted in age order; slot 0 is the oldest. A count register has width clog2(DEPTH+1).
- Reset:
  - All valid bits cleared and count = 0.
  - Outputs: is_full = 0, issue_valid = 0, issue_payload = 0.
  - Reset takes priority over flush, dispatch and issue.
- is_full: derived combinationally from the registered count only; it has no combinational path from dispatch_we or issue_ready.
- Dispatch:
  - Accepted when dispatch_we = 1, is_full = 0 and flush = 0.
  - dispatch_we while is_full = 1 is ignored; upstream must stall.
  - The new entry is appended at slot count, adjusted for any same-cycle removal.
- Wakeup:
  - For each valid slot and each source: if cdb_valid and cdb_tag == src_tag, set src_rdy at the clock edge.
  - Bypass: a dispatching entry whose source tag matches a same-cycle CDB broadcast is written with rdy = 1.
  - A woken entry becomes issue-eligible the following cycle (one-cycle wakeup-to-issue).
- Select:
  - issue_valid = OR over slots of (valid & src1_rdy & src2_rdy), forced 0 when flush = 1.
  - issue_payload = payload of the lowest-index eligible slot; 0 when issue_valid = 0.
  - Fully combinational from registered state; issue_valid and issue_payload do not depend on issue_ready.
- Issue handshake:
  - Fire = issue_valid & issue_ready. On fire the selected slot is removed and the younger slots shift down one position, preserving order.
  - While issue_ready = 0, issue_valid and the selected entry stay stable unless an older entry becomes ready. Switching to the older entry is permitted; oldest-first has priority.
- Simultaneous dispatch + issue:
  - Both occur; count is unchanged.
  - The new entry lands at index count-1 after the shift.
  - If is_full = 1, the dispatch is still refused that cycle.
- Flush:
  - All valid bits cleared and count = 0 at the edge.
  - Same-cycle dispatch is dropped and no issue fires.
  - issue_valid = 0 in the flush cycle and the next cycle.
- CDB tag matching an invalid slot: no effect.
- Multiple slots matching the same tag: all are woken.

Optional Feature:
- Macro: RS_OCCUPANCY_EN.
- Defined: adds output port `occupancy` [clog2(DEPTH+1)-1:0] equal to the registered count, plus output `issue_stall_cnt` [15:0]. The counter increments each cycle with issue_valid & ~issue_ready, saturates at 16'hFFFF, and clears on reset and on flush.
- Undefined: neither port exists and no counter logic is synthesised; all other behaviour is identical.

Test Plan:
- Reset then dispatch 4 ops with both rdy = 1, issue_ready = 1 -> issue_valid from cycle after first dispatch; payloads issue in dispatch order; is_full never asserts.
- With issue_ready = 0, dispatch DEPTH = 4 ops -> is_full = 1 after 4th edge; a 5th dispatch_we is ignored; count stays 4.
- Dispatch A (src1 tag 5, not ready) then B (ready) -> B issues first. cdb_tag = 5 -> A issue_valid one cycle later.
- Dispatch with src2_tag = 9 not ready while cdb_valid = 1 and cdb_tag = 9 in the same cycle -> entry issue-eligible next cycle.
- Full RS with dispatch_we = 1 and issue fire in the same cycle -> dispatch refused; the next cycle a dispatch is accepted and is_full returns to 1.
- 3 valid entries, assert flush with dispatch_we = 1 -> next cycle count = 0, is_full = 0, issue_valid = 0, dropped op never issues.
